// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-serial load/store engine for the MEM stage.
// Breaks byte/halfword/word accesses into single-byte memory cycles, little-endian.
module mem_access_unit #(
  parameter int MEM_DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic        r_we;
  logic        r_signed;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_asm;
  logic [31:0] r_rdata;

  logic [2:0]  w_n;
  logic [32:0] w_end;
  logic        w_err;
  logic        w_xfer;
  logic        w_last;
  logic [31:0] w_asm_next;
  logic [31:0] w_ext;
  logic [7:0]  w_wbyte;
  logic        w_unused_rdata;

  always_comb begin
    case (size_i)
      2'b00:   w_n = 3'd1;
      2'b01:   w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
  end

  // Last byte address computed in 33 bits so addresses near 2^32 cannot wrap into range.
  assign w_end = {1'b0, addr_i} + {30'b0, w_n} - 33'd1;
  assign w_err = (size_i == 2'b11)
               | ((size_i == 2'b01) & addr_i[0])
               | ((size_i == 2'b10) & (addr_i[1:0] != 2'b00))
               | (w_end >= 33'(MEM_DEPTH));

  assign w_xfer = (r_state == S_XFER);
  assign w_last = (r_cnt == r_last);

  // Assembly including the byte arriving this cycle, so the final byte lands in rdata directly.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_cnt, 3'b000} +: 8] = mem_rdata_i[7:0];
  end

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{w_asm_next[7] & r_signed}}, w_asm_next[7:0]};
      2'b01:   w_ext = {{16{w_asm_next[15] & r_signed}}, w_asm_next[15:0]};
      default: w_ext = w_asm_next;
    endcase
  end

  assign w_wbyte = r_wdata[{r_cnt, 3'b000} +: 8];
  assign w_unused_rdata = ^mem_rdata_i[31:8];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'b00;
      r_cnt    <= 2'b00;
      r_last   <= 2'b00;
      r_base   <= 32'h0;
      r_wdata  <= 32'h0;
      r_asm    <= 32'h0;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_we     <= we_i;
            r_size   <= size_i;
            r_signed <= signed_i;
            r_base   <= addr_i;
            r_wdata  <= wdata_i;
            r_err    <= w_err;
            r_cnt    <= 2'b00;
            r_last   <= 2'(w_n - 3'd1);
            r_asm    <= 32'h0;
            if (w_err) begin
              r_rdata <= 32'h0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_XFER;
            end
          end
        end
        S_XFER: begin
          if (!r_we) begin
            r_asm <= w_asm_next;
          end
          r_cnt <= r_cnt + 2'd1;
          if (w_last) begin
            r_rdata <= r_we ? 32'h0 : w_ext;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational outputs are gated by reset so they drop the instant rst_i falls.
  assign stall_o     = rst_i & (((r_state == S_IDLE) & req_i) | w_xfer);
  assign done_o      = rst_i & (r_state == S_DONE);
  assign err_o       = rst_i & (r_state == S_DONE) & r_err;
  assign rdata_o     = r_rdata;
  assign mem_addr_o  = (rst_i & w_xfer) ? (r_base + {30'b0, r_cnt}) : 32'h0;
  assign mem_we_o    = rst_i & w_xfer & r_we;
  assign mem_re_o    = rst_i & w_xfer & ~r_we;
  assign mem_wdata_o = (rst_i & w_xfer & r_we) ? {24'h0, w_wbyte} : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte memory, transaction-level model and per-cycle compare.
module tb_mem_access_unit;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall_o, done_o, err_o, mem_we, mem_re;
  logic [31:0] rdata_o, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  typedef struct packed {
    logic        stall;
    logic        done;
    logic        err;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  int cyc = 0;
  int stall_run = 0;
  int last_stall_len = 0;
  int last_done_cyc = -100;
  int done_gap = 0;
  logic last_err_seen = 1'b0;
  int pending = 0;

  mem_access_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .size_i(size),
    .signed_i(sgn), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_re_o(mem_re), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? {24'h0, mem[mem_addr[4:0]]} : 32'h0;

  always @(posedge clk) begin
    if (mem_we && (mem_addr < 32'(DEPTH))) mem[mem_addr[4:0]] <= mem_wdata[7:0];
  end

  task automatic chk1(input string name, input logic act, input logic expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the queued expectations; empty queue means quiet idle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_rdata = 32'h0;
      stall_run = 0;
    end else begin
      if (stall_o) stall_run++;
      if (done_o) begin
        last_stall_len = stall_run;
        stall_run = 0;
        done_gap = cyc - last_done_cyc;
        last_done_cyc = cyc;
        last_err_seen = err_o;
      end
    end
    if (cmp_en) begin
      if (exp_q.size() > 0) ce = exp_q.pop_front();
      else ce = '0;
      chk1("stall", stall_o, ce.stall);
      chk1("done", done_o, ce.done);
      chk1("mem_we", mem_we, ce.we);
      chk1("mem_re", mem_re, ce.re);
      chk32("mem_addr", mem_addr, ce.addr);
      chk32("mem_wdata", mem_wdata, ce.wdata);
      if (ce.done) begin
        chk1("err", err_o, ce.err);
        last_rdata = ce.rdata;
      end
      chk32("rdata", rdata_o, last_rdata);
    end
  end

  // Transaction-level model: builds the expected cycle sequence and drives one access.
  task automatic do_txn(input bit w, input logic [1:0] sz, input bit s,
                        input logic [31:0] a, input logic [31:0] wd, input bit keep);
    int n;
    bit err;
    longint val;
    exp_t e;
    int entries;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
          || (longint'(a) + n - 1 >= DEPTH);
    req = 1'b1; we = w; size = sz; sgn = s; addr = a; wdata = wd;
    e = '0; e.stall = 1'b1;
    exp_q.push_back(e);
    val = 0;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        e = '0; e.stall = 1'b1; e.addr = a + 32'(k);
        if (w) begin
          e.we = 1'b1;
          e.wdata = (wd >> (8 * k)) & 32'hFF;
          ref_mem[a + 32'(k)] = 8'(wd >> (8 * k));
        end else begin
          e.re = 1'b1;
          val = val + (longint'(ref_mem[a + 32'(k)]) << (8 * k));
        end
        exp_q.push_back(e);
      end
      if (!w && s && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
    end
    e = '0; e.done = 1'b1; e.err = err;
    e.rdata = (err || w) ? 32'h0 : val[31:0];
    exp_q.push_back(e);
    entries = err ? 2 : n + 2;
    repeat (entries - 1 + pending) @(posedge clk);
    #1;
    if (keep) begin
      pending = 1;
    end else begin
      pending = 0;
      req = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] orig2, orig3;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    mem[3] = 8'hF0;
    ref_mem[3] = 8'hF0;

    // Reset: outputs zero even with req asserted
    req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk32("rst_rdata", rdata_o, 32'h0);
    chk32("rst_addr", mem_addr, 32'h0);
    req = 1'b0;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    do_txn(1'b1, 2'd2, 1'b0, 32'd8, 32'h11223344, 1'b0);
    $display("[TB] store word @8 stall=%0d err=%0d", last_stall_len, last_err_seen);
    chk32("st_word_stall_len", 32'(last_stall_len), 32'd5);
    chk1("st_word_err", last_err_seen, 1'b0);
    chk32("st_word_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'h11223344);

    do_txn(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 1'b0);
    $display("[TB] load word @8 rdata=%h", rdata_o);
    chk32("ld_word_8", rdata_o, 32'h11223344);

    do_txn(1'b0, 2'd0, 1'b1, 32'd3, 32'h0, 1'b0);
    $display("[TB] load sbyte @3 rdata=%h", rdata_o);
    chk32("ld_sbyte_3", rdata_o, 32'hFFFFFFF0);
    chk32("ld_sbyte_stall", 32'(last_stall_len), 32'd2);

    do_txn(1'b0, 2'd0, 1'b0, 32'd3, 32'h0, 1'b0);
    $display("[TB] load ubyte @3 rdata=%h", rdata_o);
    chk32("ld_ubyte_3", rdata_o, 32'h000000F0);
    chk32("ld_ubyte_stall", 32'(last_stall_len), 32'd2);

    do_txn(1'b0, 2'd1, 1'b0, 32'd5, 32'h0, 1'b0);
    $display("[TB] load half @5 err=%0d rdata=%h", last_err_seen, rdata_o);
    chk1("ld_half_5_err", last_err_seen, 1'b1);
    chk32("ld_half_5_stall", 32'(last_stall_len), 32'd1);
    chk32("ld_half_5_rdata", rdata_o, 32'h0);

    do_txn(1'b0, 2'd2, 1'b0, 32'd28, 32'h0, 1'b0);
    $display("[TB] load word @28 err=%0d rdata=%h", last_err_seen, rdata_o);
    chk1("ld_word_28_err", last_err_seen, 1'b0);

    do_txn(1'b0, 2'd2, 1'b0, 32'd32, 32'h0, 1'b0);
    $display("[TB] load word @32 err=%0d", last_err_seen);
    chk1("ld_word_32_err", last_err_seen, 1'b1);

    do_txn(1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 1'b0);
    $display("[TB] size11 @0 err=%0d", last_err_seen);
    chk1("size11_err", last_err_seen, 1'b1);

    do_txn(1'b1, 2'd1, 1'b0, 32'd12, 32'h00008001, 1'b0);
    $display("[TB] store half @12");
    do_txn(1'b0, 2'd1, 1'b1, 32'd12, 32'h0, 1'b0);
    $display("[TB] load shalf @12 rdata=%h", rdata_o);
    chk32("ld_shalf_12", rdata_o, 32'hFFFF8001);
    do_txn(1'b0, 2'd1, 1'b0, 32'd12, 32'h0, 1'b0);
    $display("[TB] load uhalf @12 rdata=%h", rdata_o);
    chk32("ld_uhalf_12", rdata_o, 32'h00008001);

    do_txn(1'b0, 2'd2, 1'b0, 32'd29, 32'h0, 1'b0);
    $display("[TB] load word @29 err=%0d", last_err_seen);
    do_txn(1'b0, 2'd1, 1'b0, 32'd31, 32'h0, 1'b0);
    $display("[TB] load half @31 err=%0d", last_err_seen);
    chk1("ld_half_31_err", last_err_seen, 1'b1);
    do_txn(1'b0, 2'd0, 1'b0, 32'd31, 32'h0, 1'b0);
    $display("[TB] load byte @31 err=%0d rdata=%h", last_err_seen, rdata_o);
    chk1("ld_byte_31_err", last_err_seen, 1'b0);
    do_txn(1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h000000AB, 1'b0);
    $display("[TB] store byte @FFFFFFFF err=%0d", last_err_seen);
    chk1("st_byte_wrap_err", last_err_seen, 1'b1);

    // req held high through DONE: second capture waits for the following IDLE cycle
    do_txn(1'b0, 2'd0, 1'b1, 32'd3, 32'h0, 1'b1);
    do_txn(1'b0, 2'd0, 1'b0, 32'd3, 32'h0, 1'b0);
    $display("[TB] back-to-back byte loads gap=%0d rdata=%h", done_gap, rdata_o);
    chk32("b2b_done_gap", 32'(done_gap), 32'd3);
    chk32("b2b_rdata", rdata_o, 32'h000000F0);

    // Reset in the third XFER cycle of a word store at 0
    cmp_en = 1'b0;
    orig2 = ref_mem[2];
    orig3 = ref_mem[3];
    req = 1'b1; we = 1'b1; size = 2'd2; sgn = 1'b0; addr = 32'd0; wdata = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("[TB] reset mid-store stall=%b we=%b addr=%h rdata=%h", stall_o, mem_we, mem_addr, rdata_o);
    chk1("abort_stall", stall_o, 1'b0);
    chk1("abort_we", mem_we, 1'b0);
    chk1("abort_re", mem_re, 1'b0);
    chk1("abort_done", done_o, 1'b0);
    chk32("abort_addr", mem_addr, 32'h0);
    chk32("abort_wdata", mem_wdata, 32'h0);
    chk32("abort_rdata", rdata_o, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk1("abort_no_done", done_o, 1'b0);
    end
    chk32("abort_mem0", 32'(mem[0]), 32'hDD);
    chk32("abort_mem1", 32'(mem[1]), 32'hCC);
    chk32("abort_mem2", 32'(mem[2]), 32'(orig2));
    chk32("abort_mem3", 32'(mem[3]), 32'(orig3));
    ref_mem[0] = 8'hDD;
    ref_mem[1] = 8'hCC;
    @(posedge clk);
    #1;
    req = 1'b0;
    we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    do_txn(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 1'b0);
    $display("[TB] load word @0 after abort rdata=%h", rdata_o);
    chk32("post_abort_word", rdata_o, {orig3, orig2, 8'hCC, 8'hDD});

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, giving the number of byte cells in the attached data memory (legal byte addresses 0..MEM_DEPTH-1).
REQ-002 SHALL have port clk_i  in  1  single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_i  in  1  MEM-stage access request, held by the pipeline until done_o.
REQ-005 SHALL have port we_i  in  1  1 = store, 0 = load.
REQ-006 SHALL have port size_i  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 SHALL have port signed_i  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port addr_i  in  32  byte address of the access.
REQ-009 SHALL have port wdata_i  in  32  store data, right-aligned.
REQ-010 SHALL have port stall_o  out  1  pipeline freeze request.
REQ-011 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have port err_o  out  1  completion with error, valid only while done_o = 1.
REQ-013 SHALL have port rdata_o  out  32  extended load result.
REQ-014 SHALL have port mem_addr_o  out  32  byte address to the data memory.
REQ-015 SHALL have port mem_wdata_o  out  32  byte to write, in bits [7:0]; bits [31:8] = 0.
REQ-016 SHALL have port mem_we_o  out  1  byte-write strobe; the memory writes on the clk_i rising edge.
REQ-017 SHALL have port mem_re_o  out  1  read enable to the memory.
REQ-018 SHALL have port mem_rdata_i  in  32  memory read data; combinational from mem_addr_o; only bits [7:0] are used.

Function
REQ-019 SHALL implement FSM states IDLE, XFER and DONE.
REQ-020 IDLE: stall_o = req_i (combinational); on a rising edge with req_i = 1, SHALL capture we_i, size_i, signed_i, addr_i and wdata_i, and clear byte counter cnt.
REQ-021 The byte count N SHALL be 1, 2 or 4 for size 00, 01 or 10.
REQ-022 An error SHALL be flagged at capture for any of: size 11; size 01 with addr[0] = 1; size 10 with addr[1:0] != 0; or addr + N - 1 >= MEM_DEPTH.
REQ-023 On capture, IDLE SHALL go to DONE when an error is flagged, otherwise to XFER.
REQ-024 XFER: SHALL drive stall_o = 1 and mem_addr_o = base + cnt.
REQ-025 XFER store: SHALL drive mem_we_o = 1 and mem_wdata_o[7:0] = wdata[8*cnt+7:8*cnt] (little-endian).
REQ-026 XFER load: SHALL drive mem_re_o = 1 and, on each edge, latch mem_rdata_i[7:0] into assembly bits [8*cnt+7:8*cnt].
REQ-027 XFER: cnt SHALL increment each cycle; after the cycle with cnt = N-1 the FSM SHALL go to DONE.
REQ-028 DONE: SHALL last exactly one cycle with done_o = 1 and stall_o = 0; err_o = the captured error flag; the FSM SHALL then go to IDLE.
REQ-029 req_i SHALL be ignored during DONE and XFER.
REQ-030 Latency: stall_o SHALL be high for N+1 cycles (1 cycle on error) and done_o SHALL assert in the following cycle.
REQ-031 rdata_o SHALL be registered and updated on entry to DONE: loads give the assembled bytes extended from bit 8N-1 per signed_i.
REQ-032 Stores and errored accesses SHALL set rdata_o = 0.
REQ-033 rdata_o SHALL hold its value until the next DONE.
REQ-034 Outside XFER: mem_we_o = mem_re_o = 0 and mem_addr_o = mem_wdata_o = 0.
REQ-035 mem_we_o and mem_re_o SHALL never be high in the same cycle.
REQ-036 Errored accesses SHALL perform no memory access.

Reset
REQ-037 While rst_i = 0, SHALL force state IDLE, cnt = 0, all captured registers = 0, and all outputs = 0 asynchronously.
REQ-038 Reset during XFER SHALL abort the access immediately with no done_o; bytes already written SHALL remain and no rollback is performed.

Verification
REQ-039 Store word 0x11223344 at addr 8: mem_we_o high for 4 cycles, addrs 8,9,10,11, bytes 0x44,0x33,0x22,0x11, stall_o 5 cycles, then done_o=1 and err_o=0. A subsequent load word from addr 8 -> rdata_o = 0x11223344.
REQ-040 With mem[3] = 0xF0: signed byte load at addr 3 -> rdata_o = 0xFFFFFFF0; unsigned -> 0x000000F0; stall_o 2 cycles each.
REQ-041 Halfword load at addr 5 -> stall_o 1 cycle, done_o=1, err_o=1, rdata_o=0, no mem_re_o/mem_we_o pulse. Word load at addr 28 -> ok. Word load at addr 32 -> err_o=1.
REQ-042 size_i = 11 at addr 0 -> err_o=1, no memory access.
REQ-043 rst_i low in the 3rd XFER cycle of store word 0xAABBCCDD at addr 0: all outputs 0 at once, no done_o. mem[0]=0xDD and mem[1]=0xCC are written; mem[2] and mem[3] are unchanged.
REQ-044 req_i held high across DONE into the following cycle: the second capture SHALL occur only on the edge after the IDLE cycle that follows DONE, and done_o pulses SHALL be separated by at least N+1 cycles.
